// File: rtl/risk_pkg.sv
// Shared types, default widths and the limit-check helper for the
// pre-trade risk table.
`timescale 1ns/1ps

package risk_pkg;

  // Default geometry, matching the original 32-entry 16/16-bit cache.
  localparam int RISK_NUM_CLIENTS = 32;
  localparam int RISK_QTY_W       = 16;
  localparam int RISK_LIM_W       = 16;
  localparam int RISK_ACC_W       = 16;

  // Working width of the helper; any ACC_W, LIM_W, QTY_W up to 63 fits.
  localparam int RISK_MAX_W       = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_RESP
  } risk_state_t;

  typedef struct packed {
    logic                  accept;
    logic [RISK_MAX_W-1:0] new_acc;
  } risk_result_t;

  // Callers zero-extend acc/qty/limit to RISK_MAX_W. The sum keeps one bit
  // above acc_w, so a set bit at or above acc_w is a carry out of the
  // accumulator and forces a reject. On accept new_acc fits in acc_w bits.
  function automatic risk_result_t risk_check(
    input logic [RISK_MAX_W-1:0] acc,
    input logic [RISK_MAX_W-1:0] qty,
    input logic [RISK_MAX_W-1:0] limit,
    input int unsigned           acc_w
  );
    risk_result_t          r;
    logic [RISK_MAX_W-1:0] sum;
    sum       = acc + qty;
    r.new_acc = sum;
    r.accept  = ((sum >> acc_w) == '0) && (sum <= limit);
    return r;
  endfunction

endpackage

// File: rtl/risk_entry_ram.sv
// Client entry store: DEPTH x WIDTH, one read port and one write port,
// synchronous read, no reset.
`timescale 1ns/1ps

module risk_entry_ram #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port.
  // NOTE: the array has no reset so it maps onto block RAM; validity is
  // tracked outside in a resettable vector. Non-blocking assignments keep
  // read-before-write ordering identical in simulation and hardware.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/risk_limit_table.sv
// Pre-trade risk table: per-client limit and accumulated exposure with a
// read/check/commit FSM, one transaction in flight.
// Optional build macro RISK_STATS_EN adds saturating accept/reject counters;
// without it cnt_accept/cnt_reject are tied to zero.
// ACC_W must be >= QTY_W and NUM_CLIENTS must be at least 2.
`timescale 1ns/1ps

module risk_limit_table
  import risk_pkg::*;
#(
  parameter  int NUM_CLIENTS = RISK_NUM_CLIENTS,
  parameter  int QTY_W       = RISK_QTY_W,
  parameter  int LIM_W       = RISK_LIM_W,
  parameter  int ACC_W       = RISK_ACC_W,
  localparam int CID_W       = $clog2(NUM_CLIENTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ord_valid,
  output logic             ord_ready,
  input  logic [CID_W-1:0] ord_client,
  input  logic [QTY_W-1:0] ord_qty,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CID_W-1:0] cfg_client,
  input  logic [LIM_W-1:0] cfg_limit,
  input  logic             cfg_clear,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_accept,
  output logic [CID_W-1:0] res_client,
  output logic [ACC_W-1:0] res_acc,
  output logic [31:0]      cnt_accept,
  output logic [31:0]      cnt_reject
);

  localparam int ENT_W = LIM_W + ACC_W;

  risk_state_t state_q, state_d;

  logic [NUM_CLIENTS-1:0] entry_valid_q;
  logic                   cfg_pend_q;

  // Latched config request, written back one cycle after its read.
  logic [CID_W-1:0] cfg_client_q;
  logic [LIM_W-1:0] cfg_limit_q;
  logic             cfg_keep_q;

  // Latched order and the entry it read.
  logic [CID_W-1:0] ord_client_q;
  logic [QTY_W-1:0] ord_qty_q;
  logic             ent_valid_q;
  logic [LIM_W-1:0] ent_limit_q;
  logic [ACC_W-1:0] ent_acc_q;

  // RAM ports.
  logic             ram_re;
  logic [CID_W-1:0] ram_raddr;
  logic [ENT_W-1:0] ram_rdata;
  logic             ram_we;
  logic [CID_W-1:0] ram_waddr;
  logic [ENT_W-1:0] ram_wdata;

  logic [LIM_W-1:0] ram_rd_lim;
  logic [ACC_W-1:0] ram_rd_acc;
  logic [ACC_W-1:0] cfg_new_acc;

  risk_result_t     chk;
  logic             chk_accept;
  logic [ACC_W-1:0] chk_acc;
  logic             unused_chk_hi;

  risk_entry_ram #(
    .DEPTH (NUM_CLIENTS),
    .WIDTH (ENT_W)
  ) u_ram (
    .clk     (clk),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata)
  );

  assign ram_rd_lim = ram_rdata[ENT_W-1:ACC_W];
  assign ram_rd_acc = ram_rdata[ACC_W-1:0];

  // A reconfigure keeps the running exposure unless asked to clear it or
  // the entry had never been configured (its RAM word is garbage).
  assign cfg_new_acc = cfg_keep_q ? ram_rd_acc : ACC_W'(0);

  assign chk = risk_check(RISK_MAX_W'(ent_acc_q), RISK_MAX_W'(ord_qty_q),
                          RISK_MAX_W'(ent_limit_q), ACC_W);
  assign chk_accept    = ent_valid_q && chk.accept;
  assign chk_acc       = chk.new_acc[ACC_W-1:0];
  assign unused_chk_hi = ^chk.new_acc[RISK_MAX_W-1:ACC_W];

  // Next-state, handshakes and RAM port control.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    ord_ready = 1'b0;
    cfg_ready = 1'b0;
    ram_re    = 1'b0;
    ram_raddr = ord_client;
    ram_we    = 1'b0;
    ram_waddr = cfg_client_q;
    ram_wdata = {cfg_limit_q, cfg_new_acc};
    unique case (state_q)
      S_IDLE: begin
        if (cfg_pend_q) begin
          // Write half of the config read-modify-write; both ports stalled.
          ram_we = 1'b1;
        end else begin
          cfg_ready = 1'b1;
          ord_ready = !cfg_valid;
          if (cfg_valid) begin
            ram_re    = 1'b1;
            ram_raddr = cfg_client;
          end else if (ord_valid) begin
            ram_re  = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (chk_accept) begin
          ram_we    = 1'b1;
          ram_waddr = ord_client_q;
          ram_wdata = {ent_limit_q, chk_acc};
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Config write-pending flag and per-client valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_pend_q    <= 1'b0;
      entry_valid_q <= '0;
    end else begin
      cfg_pend_q <= cfg_valid && cfg_ready;
      if (cfg_pend_q) entry_valid_q[cfg_client_q] <= 1'b1;
    end
  end

  // Transaction datapath; each register is only consumed after the
  // handshake or state that loads it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cfg_valid && cfg_ready) begin
      cfg_client_q <= cfg_client;
      cfg_limit_q  <= cfg_limit;
      cfg_keep_q   <= entry_valid_q[cfg_client] && !cfg_clear;
    end
    if (ord_valid && ord_ready) begin
      ord_client_q <= ord_client;
      ord_qty_q    <= ord_qty;
    end
    if (state_q == S_READ) begin
      ent_valid_q <= entry_valid_q[ord_client_q];
      ent_limit_q <= entry_valid_q[ord_client_q] ? ram_rd_lim : LIM_W'(0);
      ent_acc_q   <= entry_valid_q[ord_client_q] ? ram_rd_acc : ACC_W'(0);
    end
  end

  // Decision register: loaded on the check edge, held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_accept <= 1'b0;
      res_client <= '0;
      res_acc    <= '0;
    end else if (state_q == S_CHECK) begin
      res_valid  <= 1'b1;
      res_accept <= chk_accept;
      res_client <= ord_client_q;
      res_acc    <= chk_accept ? chk_acc : ent_acc_q;
    end else if (state_q == S_RESP && res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef RISK_STATS_EN
  logic [31:0] cnt_accept_q;
  logic [31:0] cnt_reject_q;

  // Saturating decision counters, bumped on the check edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_accept_q <= '0;
      cnt_reject_q <= '0;
    end else if (state_q == S_CHECK) begin
      if (chk_accept) begin
        if (cnt_accept_q != 32'hFFFF_FFFF) cnt_accept_q <= cnt_accept_q + 32'd1;
      end else begin
        if (cnt_reject_q != 32'hFFFF_FFFF) cnt_reject_q <= cnt_reject_q + 32'd1;
      end
    end
  end

  assign cnt_accept = cnt_accept_q;
  assign cnt_reject = cnt_reject_q;
`else
  assign cnt_accept = 32'd0;
  assign cnt_reject = 32'd0;
`endif

  // The decision must not change while the consumer is stalling.
  a_res_stable: assert property (@(posedge clk) disable iff (rst)
    (res_valid && !res_ready) |=>
      (res_valid && $stable(res_accept) && $stable(res_client) && $stable(res_acc)));

  // No write may leave an entry's exposure above its limit.
  a_acc_le_limit: assert property (@(posedge clk) disable iff (rst)
    ram_we |-> (RISK_MAX_W'(ram_wdata[ACC_W-1:0]) <= RISK_MAX_W'(ram_wdata[ENT_W-1:ACC_W])));

endmodule

// File: tb/tb_risk_limit_table.sv
// Directed self-checking bench for risk_limit_table (default parameters).
`timescale 1ns/1ps

module tb_risk_limit_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ord_valid = 1'b0;
  logic        ord_ready;
  logic [4:0]  ord_client = '0;
  logic [15:0] ord_qty = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [4:0]  cfg_client = '0;
  logic [15:0] cfg_limit = '0;
  logic        cfg_clear = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        res_accept;
  logic [4:0]  res_client;
  logic [15:0] res_acc;
  logic [31:0] cnt_accept;
  logic [31:0] cnt_reject;

  int checks = 0;
  int errors = 0;

  risk_limit_table dut (
    .clk        (clk),
    .rst        (rst),
    .ord_valid  (ord_valid),
    .ord_ready  (ord_ready),
    .ord_client (ord_client),
    .ord_qty    (ord_qty),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_client (cfg_client),
    .cfg_limit  (cfg_limit),
    .cfg_clear  (cfg_clear),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_accept (res_accept),
    .res_client (res_client),
    .res_acc    (res_acc),
    .cnt_accept (cnt_accept),
    .cnt_reject (cnt_reject)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- drivers (no checking) ----------------

  task automatic apply_reset();
    rst       = 1'b1;
    ord_valid = 1'b0;
    cfg_valid = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the first negedge where res_valid is seen; lat counts
  // negedges after the accepting edge (1 = first one).
  task automatic wait_result(output logic acc_o, output logic [15:0] racc,
                             output logic [4:0] rcl, output int lat, output bit to);
    to = 1'b1; lat = 0; acc_o = 1'b0; racc = '0; rcl = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        lat = i; acc_o = res_accept; racc = res_acc; rcl = res_client; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic send_order(input logic [4:0] cl, input logic [15:0] q,
                            output logic acc_o, output logic [15:0] racc,
                            output logic [4:0] rcl, output int lat, output bit to);
    bit got;
    @(negedge clk);
    ord_valid = 1'b1; ord_client = cl; ord_qty = q;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ord_ready === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 ord_valid = 1'b0;
    if (!got) begin
      to = 1'b1; acc_o = 1'b0; racc = '0; rcl = '0; lat = 0;
    end else begin
      wait_result(acc_o, racc, rcl, lat, to);
    end
  endtask

  task automatic do_cfg(input logic [4:0] cl, input logic [15:0] lim,
                        input logic clr, output bit to);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_client = cl; cfg_limit = lim; cfg_clear = clr;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cfg_ready === 1'b1) begin to = 1'b0; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    @(posedge clk);
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({res_valid, res_accept, res_client, res_acc} !== 23'd0) begin
      errors++;
      $display("FAIL reset_res: got v=%b a=%b c=%0d acc=%h, want all 0",
               res_valid, res_accept, res_client, res_acc);
    end
    checks++;
    if ({ord_ready, cfg_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got ord=%b cfg=%b, want 1 1", ord_ready, cfg_ready);
    end
    checks++;
    if ({cnt_accept, cnt_reject} !== 64'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d, want 0/0", cnt_accept, cnt_reject);
    end
  endtask

  task automatic test_unconfigured();
    logic a; logic [15:0] r; logic [4:0] c; int lat; bit to;
    send_order(5'd5, 16'd10, a, r, c, lat, to);
    checks++;
    if ({to, a, r, c} !== {1'b0, 1'b0, 16'd0, 5'd5}) begin
      errors++;
      $display("FAIL unconfigured: got to=%b acc=%b res_acc=%h cl=%0d, want to=0 acc=0 res_acc=0000 cl=5",
               to, a, r, c);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL latency: got %0d, want 3", lat);
    end
  endtask

  task automatic test_accumulate();
    logic [15:0] qty   [4] = '{16'd40, 16'd40, 16'd20, 16'd1};
    logic        e_acc [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] e_res [4] = '{16'd40, 16'd80, 16'd100, 16'd100};
    logic a; logic [15:0] r; logic [4:0] c; int lat; bit to;
    do_cfg(5'd3, 16'd100, 1'b1, to);
    checks++;
    if (to) begin errors++; $display("FAIL cfg_timeout: cfg_ready got 0, want 1"); end
    for (int i = 0; i < 4; i++) begin
      send_order(5'd3, qty[i], a, r, c, lat, to);
      checks++;
      if ({to, a, r, c} !== {1'b0, e_acc[i], e_res[i], 5'd3}) begin
        errors++;
        $display("FAIL accum[%0d]: got to=%b acc=%b res_acc=%0d cl=%0d, want acc=%b res_acc=%0d cl=3",
                 i, to, a, r, c, e_acc[i], e_res[i]);
      end
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL accum_latency[%0d]: got %0d, want 3", i, lat);
      end
    end
    // Handshake completes on the next edge; FSM must be back in idle right after.
    @(negedge clk);
    checks++;
    if ({res_valid, ord_ready} !== 2'b01) begin
      errors++;
      $display("FAIL back_to_idle: got res_valid=%b ord_ready=%b, want 0 1", res_valid, ord_ready);
    end
  endtask

  task automatic test_overflow();
    logic a; logic [15:0] r; logic [4:0] c; int lat; bit to;
    do_cfg(5'd7, 16'hFFFF, 1'b1, to);
    send_order(5'd7, 16'hFFF0, a, r, c, lat, to);
    checks++;
    if ({to, a, r} !== {1'b0, 1'b1, 16'hFFF0}) begin
      errors++;
      $display("FAIL ovf_first: got to=%b acc=%b res_acc=%h, want acc=1 res_acc=fff0", to, a, r);
    end
    send_order(5'd7, 16'h0020, a, r, c, lat, to);
    checks++;
    if ({to, a, r} !== {1'b0, 1'b0, 16'hFFF0}) begin
      errors++;
      $display("FAIL ovf_carry: got to=%b acc=%b res_acc=%h, want acc=0 res_acc=fff0", to, a, r);
    end
    send_order(5'd7, 16'h0000, a, r, c, lat, to);
    checks++;
    if ({to, a, r} !== {1'b0, 1'b1, 16'hFFF0}) begin
      errors++;
      $display("FAIL qty_zero: got to=%b acc=%b res_acc=%h, want acc=1 res_acc=fff0", to, a, r);
    end
  endtask

  task automatic test_cfg_priority();
    logic a; logic [15:0] r; logic [4:0] c; int lat; bit to;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_client = 5'd9; cfg_limit = 16'd50; cfg_clear = 1'b1;
    ord_valid = 1'b1; ord_client = 5'd9; ord_qty = 16'd50;
    #1;
    checks++;
    if ({cfg_ready, ord_ready} !== 2'b10) begin
      errors++;
      $display("FAIL prio: got cfg_ready=%b ord_ready=%b, want 1 0", cfg_ready, ord_ready);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    checks++;
    if ({cfg_ready, ord_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rmw_stall: got cfg_ready=%b ord_ready=%b, want 0 0", cfg_ready, ord_ready);
    end
    @(negedge clk);
    checks++;
    if (ord_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_cfg_ready: got ord_ready=%b, want 1", ord_ready);
    end
    @(posedge clk);
    #1 ord_valid = 1'b0;
    wait_result(a, r, c, lat, to);
    checks++;
    if ({to, a, r} !== {1'b0, 1'b1, 16'd50}) begin
      errors++;
      $display("FAIL cfg_then_order: got to=%b acc=%b res_acc=%0d, want acc=1 res_acc=50", to, a, r);
    end
    send_order(5'd9, 16'd100, a, r, c, lat, to);
    checks++;
    if ({to, a, r} !== {1'b0, 1'b0, 16'd50}) begin
      errors++;
      $display("FAIL over_limit: got to=%b acc=%b res_acc=%0d, want acc=0 res_acc=50", to, a, r);
    end
    do_cfg(5'd9, 16'd200, 1'b0, to);
    send_order(5'd9, 16'd100, a, r, c, lat, to);
    checks++;
    if ({to, a, r} !== {1'b0, 1'b1, 16'd150}) begin
      errors++;
      $display("FAIL raise_keep: got to=%b acc=%b res_acc=%0d, want acc=1 res_acc=150", to, a, r);
    end
  endtask

  task automatic test_backpressure_reset();
    logic a; logic [15:0] r; logic [4:0] c; int lat; bit to;
    logic [21:0] snap;
    do_cfg(5'd12, 16'd30, 1'b1, to);
    res_ready = 1'b0;
    send_order(5'd12, 16'd10, a, r, c, lat, to);
    checks++;
    if ({to, a, r, c} !== {1'b0, 1'b1, 16'd10, 5'd12}) begin
      errors++;
      $display("FAIL bp_decision: got to=%b acc=%b res_acc=%0d cl=%0d, want acc=1 res_acc=10 cl=12",
               to, a, r, c);
    end
    snap = {1'b1, 5'd12, 16'd10};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, res_accept, res_client, res_acc, ord_ready, cfg_ready} !== {1'b1, snap, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b a=%b c=%0d acc=%0d ord=%b cfg=%b, want v=1 a=1 c=12 acc=10 ord=0 cfg=0",
                 i, res_valid, res_accept, res_client, res_acc, ord_ready, cfg_ready);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_resp: got res_valid=%b, want 0", res_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    #1;
    checks++;
    if ({ord_ready, cfg_ready} !== 2'b11) begin
      errors++;
      $display("FAIL rst_release_ready: got ord=%b cfg=%b, want 1 1", ord_ready, cfg_ready);
    end
    send_order(5'd12, 16'd10, a, r, c, lat, to);
    checks++;
    if ({to, a, r} !== {1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL after_rst_invalid: got to=%b acc=%b res_acc=%0d, want acc=0 res_acc=0", to, a, r);
    end
  endtask

  task automatic test_stats();
    logic [4:0]  cl [5] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd2};
    logic [15:0] q  [5] = '{16'd5, 16'd5, 16'd1, 16'd0, 16'd3};
    logic a; logic [15:0] r; logic [4:0] c; int lat; bit to;
    logic [31:0] e_acc, e_rej;
    apply_reset();
    do_cfg(5'd1, 16'd10, 1'b1, to);
    for (int i = 0; i < 5; i++) send_order(cl[i], q[i], a, r, c, lat, to);
`ifdef RISK_STATS_EN
    e_acc = 32'd3; e_rej = 32'd2;
`else
    e_acc = 32'd0; e_rej = 32'd0;
`endif
    checks++;
    if ({cnt_accept, cnt_reject} !== {e_acc, e_rej}) begin
      errors++;
      $display("FAIL stats: got %0d/%0d, want %0d/%0d", cnt_accept, cnt_reject, e_acc, e_rej);
    end
  endtask

  initial begin
    test_reset();
    test_unconfigured();
    test_accumulate();
    test_overflow();
    test_cfg_priority();
    test_backpressure_reset();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
